mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds one instruction between EX and WB,
// waits for the data_sram response of loads/stores, extracts load data,
// buffers it while WB is stalled, and drops stale responses after a flush.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   // EX -> MEM handshake and payload
   input  logic        ex_mem_valid,
   output logic        mem_allowin,
   input  logic        ex_gr_we,
   input  logic        ex_res_from_mem,
   input  logic        ex_ex,
   input  logic        ex_req_sent,
   input  logic [2:0]  ex_mem_type,
   input  logic [1:0]  ex_addr_low2,
   input  logic [4:0]  ex_dest,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_result,
   // data_sram response channel
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   // WB side
   input  logic        wb_ex,
   output logic        mem_wb_valid,
   input  logic        wb_allowin,
   output logic        mem_wb_gr_we,
   output logic [4:0]  mem_wb_dest,
   output logic [31:0] mem_wb_pc,
   output logic [31:0] mem_wb_result,
   output logic        mem_wb_ex,
   // bypass to ID
   output logic        mem_fwd_valid,
   output logic [4:0]  mem_fwd_dest,
   output logic [31:0] mem_fwd_result,
   output logic        mem_ld_pending
);

   // Response-tracking states
   localparam logic [1:0] S_IDLE = 2'd0;  // no access outstanding
   localparam logic [1:0] S_WAIT = 2'd1;  // request sent, waiting for data_ok
   localparam logic [1:0] S_HOLD = 2'd2;  // response buffered, WB stalled

   // Load type encodings
   localparam logic [2:0] LD_B  = 3'd0;
   localparam logic [2:0] LD_H  = 3'd1;
   localparam logic [2:0] LD_W  = 3'd2;
   localparam logic [2:0] LD_BU = 3'd3;
   localparam logic [2:0] LD_HU = 3'd4;

   logic [1:0]  r_state;
   logic        r_mem_valid;
   logic        r_cancel;      // a flushed access still owes us one data_ok

   logic        r_gr_we;
   logic        r_res_from_mem;
   logic        r_ex;
   logic [2:0]  r_mem_type;
   logic [1:0]  r_addr_low2;
   logic [4:0]  r_dest;
   logic [31:0] r_pc;
   logic [31:0] r_result;
   logic [31:0] r_rdata_buf;

   logic        w_ready_go;
   logic        w_accept;
   logic        w_leave;
   logic [31:0] w_load_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   // Stage may hand its instruction on: only an outstanding access holds it back
   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
      w_ready_go = 1'b1;
      case (r_state)
         S_WAIT:  w_ready_go = data_sram_data_ok;
         default: w_ready_go = 1'b1;
      endcase
   end

   // A cancelled access blocks new entries until its response has drained
   assign mem_allowin  = ~r_cancel & (~r_mem_valid | (w_ready_go & wb_allowin));
   assign w_accept     = ex_mem_valid & mem_allowin;
   assign mem_wb_valid = r_mem_valid & w_ready_go;
   assign w_leave      = mem_wb_valid & wb_allowin;

   // Control state: valid bit, response tracking and flush cancellation
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (reset) begin
         r_mem_valid <= 1'b0;
         r_state     <= S_IDLE;
         r_cancel    <= 1'b0;
      end else if (wb_ex) begin
         // Flush wins over any accept; a response still in flight must be swallowed
         r_mem_valid <= 1'b0;
         r_state     <= S_IDLE;
         r_cancel    <= (r_cancel | (r_state == S_WAIT)) & ~data_sram_data_ok;
      end else begin
         if (r_cancel && data_sram_data_ok) begin
            r_cancel <= 1'b0;
         end
         if (w_accept) begin
            r_mem_valid <= 1'b1;
            r_state     <= (ex_req_sent & ~ex_ex) ? S_WAIT : S_IDLE;
         end else if (w_leave) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_IDLE;
         end else if ((r_state == S_WAIT) && data_sram_data_ok) begin
            r_state <= S_HOLD;
         end
      end
   end

   // Payload registers: captured on accept, qualified by r_mem_valid downstream
   always_ff @(posedge clk) begin
      // NOTE: datapath registers carry no reset; every consumer is gated by a reset valid bit.
      if (w_accept) begin
         r_gr_we        <= ex_gr_we;
         r_res_from_mem <= ex_res_from_mem;
         r_ex           <= ex_ex;
         r_mem_type     <= ex_mem_type;
         r_addr_low2    <= ex_addr_low2;
         r_dest         <= ex_dest;
         r_pc           <= ex_pc;
         r_result       <= ex_result;
      end
   end

   // Response buffer: keeps the read data while WB is not ready to take it
   always_ff @(posedge clk) begin
      if ((r_state == S_WAIT) && data_sram_data_ok) begin
         r_rdata_buf <= data_sram_rdata;
      end
   end

   // Once buffered, the live bus no longer belongs to this instruction
   assign w_load_word = (r_state == S_HOLD) ? r_rdata_buf : data_sram_rdata;
   assign w_byte      = 8'(w_load_word >> {r_addr_low2, 3'b000});
   assign w_half      = 16'(w_load_word >> {r_addr_low2[1], 4'b0000});

   // Load extraction with sign/zero extension by load type
   always_comb begin
      w_load_data = w_load_word;
      case (r_mem_type)
         LD_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
         LD_H:    w_load_data = {{16{w_half[15]}}, w_half};
         LD_W:    w_load_data = w_load_word;
         LD_BU:   w_load_data = {24'd0, w_byte};
         LD_HU:   w_load_data = {16'd0, w_half};
         default: w_load_data = w_load_word;
      endcase
   end

   assign mem_wb_result  = r_res_from_mem ? w_load_data : r_result;
   assign mem_wb_gr_we   = r_gr_we & ~r_ex;
   assign mem_wb_ex      = r_ex;
   assign mem_wb_dest    = r_dest;
   assign mem_wb_pc      = r_pc;

   // Bypass: a load's value is only forwardable once its data has arrived
   assign mem_fwd_valid  = r_mem_valid & r_gr_we & ~r_ex & ~(r_res_from_mem & ~w_ready_go);
   assign mem_ld_pending = r_mem_valid & r_res_from_mem & ~w_ready_go;
   assign mem_fwd_dest   = mem_wb_dest;
   assign mem_fwd_result = mem_wb_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed bench for mem_stage. The bench plays
// EX, data_sram and WB, and predicts every output from a transaction-level
// model (one instruction slot, one outstanding response, load value arithmetic).
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_mem_valid;
   logic        mem_allowin;
   logic        ex_gr_we, ex_res_from_mem, ex_ex, ex_req_sent;
   logic [2:0]  ex_mem_type;
   logic [1:0]  ex_addr_low2;
   logic [4:0]  ex_dest;
   logic [31:0] ex_pc, ex_result;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        wb_ex;
   logic        mem_wb_valid;
   logic        wb_allowin;
   logic        mem_wb_gr_we;
   logic [4:0]  mem_wb_dest;
   logic [31:0] mem_wb_pc, mem_wb_result;
   logic        mem_wb_ex;
   logic        mem_fwd_valid;
   logic [4:0]  mem_fwd_dest;
   logic [31:0] mem_fwd_result;
   logic        mem_ld_pending;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset(reset),
      .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
      .ex_gr_we(ex_gr_we), .ex_res_from_mem(ex_res_from_mem), .ex_ex(ex_ex),
      .ex_req_sent(ex_req_sent), .ex_mem_type(ex_mem_type), .ex_addr_low2(ex_addr_low2),
      .ex_dest(ex_dest), .ex_pc(ex_pc), .ex_result(ex_result),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .wb_ex(wb_ex), .mem_wb_valid(mem_wb_valid), .wb_allowin(wb_allowin),
      .mem_wb_gr_we(mem_wb_gr_we), .mem_wb_dest(mem_wb_dest), .mem_wb_pc(mem_wb_pc),
      .mem_wb_result(mem_wb_result), .mem_wb_ex(mem_wb_ex),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_dest(mem_fwd_dest),
      .mem_fwd_result(mem_fwd_result), .mem_ld_pending(mem_ld_pending)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  dest;
      logic        gr_we, ex, ld, req;
      logic [2:0]  mtype;
      logic [1:0]  a;
      logic [31:0] alu, rdata, exp_res;
      logic        resp_done;
   } instr_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_retired = 0;
   logic [31:0] pc_ctr = 32'h1c00_0000;

   // model state
   instr_t      ex_i, cur;
   bit          ex_hold = 0, has = 0;
   bit          resp_pending = 0, resp_flushed = 0;
   int          resp_delay = 0;
   logic [31:0] resp_rdata = '0;
   // per-cycle knobs
   int          next_delay = 0;
   bit          k_wb_allowin = 1, k_wb_ex = 0, k_stray = 0;
   // last observed outputs
   logic        o_allow, o_wbv, o_ldp, o_fwdv, o_grwe, o_ex;
   logic [31:0] o_res;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Architectural value of a load, from byte/halfword arithmetic
   function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] t,
                                              input logic [1:0] a);
      int unsigned bv, hv;
      bv = (w >> (8 * a)) % 256;
      hv = (w >> (16 * (a / 2))) % 65536;
      case (t)
         3'd0:    return (bv >= 128) ? bv - 256 : bv;
         3'd1:    return (hv >= 32768) ? hv - 65536 : hv;
         3'd3:    return bv;
         3'd4:    return hv;
         default: return w;
      endcase
   endfunction

   // kind: 0 alu, 1 load, 2 store, 3 excepted
   task automatic make(input int kind, input logic [2:0] t, input logic [1:0] a,
                       input logic [31:0] val, input logic [31:0] rd);
      ex_i.pc    = pc_ctr;
      pc_ctr     = pc_ctr + 4;
      ex_i.dest  = 5'($urandom_range(1, 31));
      ex_i.mtype = t;
      ex_i.a     = a;
      ex_i.alu   = val;
      ex_i.rdata = rd;
      ex_i.gr_we = (kind != 2);
      ex_i.ex    = (kind == 3);
      ex_i.ld    = (kind == 1);
      ex_i.req   = (kind == 1) || (kind == 2);
      ex_i.exp_res   = ex_i.ld ? load_value(rd, t, a) : val;
      ex_i.resp_done = 1'b0;
      ex_hold = 1;
   endtask

   // One clock cycle: drive at negedge, check #1 later, advance the model
   task automatic step();
      bit resp_now, ready, exp_allow, accept, retire;
      @(negedge clk);
      resp_now          = resp_pending && (resp_delay == 0);
      data_sram_data_ok = resp_now || (k_stray && !resp_pending);
      data_sram_rdata   = resp_now ? resp_rdata : $urandom;
      wb_allowin        = k_wb_allowin;
      wb_ex             = k_wb_ex;
      ex_mem_valid      = ex_hold && !k_wb_ex;
      ex_gr_we          = ex_i.gr_we;
      ex_res_from_mem   = ex_i.ld;
      ex_ex             = ex_i.ex;
      ex_req_sent       = ex_i.req;
      ex_mem_type       = ex_i.mtype;
      ex_addr_low2      = ex_i.a;
      ex_dest           = ex_i.dest;
      ex_pc             = ex_i.pc;
      ex_result         = ex_i.alu;
      #1;
      ready     = has && (!cur.req || cur.resp_done || resp_now);
      exp_allow = !resp_flushed && (!has || (ready && k_wb_allowin));
      o_allow = mem_allowin; o_wbv = mem_wb_valid; o_ldp = mem_ld_pending;
      o_fwdv = mem_fwd_valid; o_grwe = mem_wb_gr_we; o_ex = mem_wb_ex; o_res = mem_wb_result;
      check("allowin", 32'(mem_allowin), 32'(exp_allow));
      check("wb_valid", 32'(mem_wb_valid), 32'(ready));
      check("fwd_valid", 32'(mem_fwd_valid),
            32'(has && cur.gr_we && !cur.ex && !(cur.ld && !ready)));
      check("ld_pending", 32'(mem_ld_pending), 32'(has && cur.ld && !ready));
      if (ready) begin
         check("result", mem_wb_result, cur.exp_res);
         check("fwd_result", mem_fwd_result, cur.exp_res);
         check("pc", mem_wb_pc, cur.pc);
         check("dest", {mem_wb_dest, mem_fwd_dest}, {cur.dest, cur.dest});
         check("flags", {mem_wb_gr_we, mem_wb_ex}, {cur.gr_we && !cur.ex, cur.ex});
      end
      accept = ex_hold && exp_allow && !k_wb_ex;
      retire = ready && k_wb_allowin && !k_wb_ex;
      if (k_wb_ex) begin
         has = 0;
         ex_hold = 0;
         if (resp_pending && !resp_now) resp_flushed = 1;
      end else if (retire) begin
         has = 0;
         n_retired++;
      end else if (has && resp_now) begin
         cur.resp_done = 1;
      end
      if (resp_now) begin
         resp_pending = 0;
         resp_flushed = 0;
      end else if (resp_pending) begin
         resp_delay--;
      end
      if (accept) begin
         cur = ex_i;
         has = 1;
         ex_hold = 0;
         if (cur.req) begin
            resp_pending = 1;
            resp_delay   = next_delay;
            resp_rdata   = cur.rdata;
         end
      end
      k_wb_ex = 0;
      k_stray = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; ex_mem_valid = 0; data_sram_data_ok = 0; wb_ex = 0; wb_allowin = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      has = 0; ex_hold = 0; resp_pending = 0; resp_flushed = 0;
      k_wb_ex = 0; k_stray = 0; k_wb_allowin = 1;
   endtask

   initial begin
      bit          seen;
      int          pend;
      logic [31:0] got;
      reset = 1; ex_mem_valid = 0; ex_gr_we = 0; ex_res_from_mem = 0; ex_ex = 0;
      ex_req_sent = 0; ex_mem_type = 0; ex_addr_low2 = 0; ex_dest = 0; ex_pc = 0;
      ex_result = 0; data_sram_data_ok = 0; data_sram_rdata = 0; wb_ex = 0; wb_allowin = 1;
      make(0, 3'd0, 2'd0, 32'd0, 32'd0);
      ex_hold = 0;

      // reset state
      do_reset();
      step();
      check("rst_wb_valid", 32'(o_wbv), 32'd0);
      check("rst_fwd_valid", 32'(o_fwdv), 32'd0);
      check("rst_ld_pending", 32'(o_ldp), 32'd0);
      check("rst_allowin", 32'(o_allow), 32'd1);

      // add.w passes straight through
      make(0, 3'd0, 2'd0, 32'h0000_1234, 32'd0);
      step();
      step();
      check("add_valid", 32'(o_wbv), 32'd1);
      check("add_result", o_res, 32'h0000_1234);
      check("add_gr_we", 32'(o_grwe), 32'd1);

      // ld.b, byte 3 of 0x80FF0000, response two cycles after entry
      next_delay = 2;
      make(1, 3'd0, 2'd3, $urandom, 32'h80FF_0000);
      step();
      seen = 0; pend = 0; got = '0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (o_ldp) pend++;
         if (o_wbv) begin seen = 1; got = o_res; end
      end
      check("ldb_seen", 32'(seen), 32'd1);
      check("ldb_result", got, 32'hFFFF_FF80);
      check("ldb_pending_cycles", 32'(pend), 32'd2);

      // ld.hu into HOLD while WB stalls for three cycles
      next_delay = 1;
      make(1, 3'd4, 2'd2, $urandom, {16'h8001, 16'($urandom)});
      step();
      k_wb_allowin = 0;
      step();
      step();
      check("ldhu_valid", 32'(o_wbv), 32'd1);
      check("ldhu_result", o_res, 32'h0000_8001);
      for (int i = 0; i < 3; i++) begin
         k_wb_allowin = 0;
         step();
         check("ldhu_hold_result", o_res, 32'h0000_8001);
      end
      k_wb_allowin = 1;
      step();
      step();
      check("ldhu_retired", 32'(o_wbv), 32'd0);

      // ld.w flushed in WAIT; its response arrives two cycles later
      next_delay = 3;
      make(1, 3'd2, 2'd0, $urandom, $urandom);
      step();
      step();
      k_wb_ex = 1;
      step();
      make(0, 3'd0, 2'd0, 32'hCAFE_0001, 32'd0);
      step();
      check("flush_allowin_a", 32'(o_allow), 32'd0);
      check("flush_valid_a", 32'(o_wbv), 32'd0);
      step();
      check("flush_allowin_b", 32'(o_allow), 32'd0);
      check("flush_valid_b", 32'(o_wbv), 32'd0);
      step();
      check("flush_allowin_c", 32'(o_allow), 32'd1);
      step();
      check("post_flush_result", o_res, 32'hCAFE_0001);

      // excepted instruction does not wait and does not write
      make(3, 3'd0, 2'd0, $urandom, 32'd0);
      step();
      step();
      check("exc_valid", 32'(o_wbv), 32'd1);
      check("exc_ex", 32'(o_ex), 32'd1);
      check("exc_gr_we", 32'(o_grwe), 32'd0);
      check("exc_fwd_valid", 32'(o_fwdv), 32'd0);

      // back-to-back ld.w, one result per cycle
      next_delay = 0;
      step();
      make(1, 3'd2, 2'd0, $urandom, 32'hA500_0000);
      step();
      for (int k = 1; k <= 4; k++) begin
         if (k < 4) make(1, 3'd2, 2'd0, $urandom, 32'hA500_0000 + 32'(k));
         step();
         check("b2b_valid", 32'(o_wbv), 32'd1);
         check("b2b_result", o_res, 32'hA500_0000 + 32'(k - 1));
      end

      // reset while waiting, then a stray data_ok must be ignored
      next_delay = 3;
      make(1, 3'd2, 2'd0, $urandom, $urandom);
      step();
      step();
      do_reset();
      k_stray = 1;
      step();
      check("rst_wait_allowin", 32'(o_allow), 32'd1);
      make(0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'd0);
      step();
      step();
      check("rst_wait_next", o_res, 32'h0BAD_F00D);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (!ex_hold && $urandom_range(0, 3) != 0) begin
            int r;
            r = $urandom_range(0, 9);
            make((r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3,
                 3'($urandom_range(0, 4)), 2'($urandom), $urandom, $urandom);
         end
         k_wb_allowin = ($urandom_range(0, 3) != 0);
         k_wb_ex      = ($urandom_range(0, 19) == 0);
         k_stray      = ($urandom_range(0, 9) == 0);
         next_delay   = $urandom_range(0, 3);
         step();
      end
      check("progress", 32'(n_retired > 300), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
